// File: rtl/p_issue_queue_pkg.sv
// Shared types and default sizing for the per-FU issue queues and the dispatch stage
// that feeds them.
package p_issue_queue_pkg;

  localparam int IQ_DEPTH  = 8;
  localparam int IQ_DATA_W = 32;
  localparam int IQ_PREG_W = 6;
  localparam int IQ_CTRL_W = 16;

  typedef struct packed {
    logic [1:0][IQ_DATA_W-1:0] data;
    logic [1:0][IQ_PREG_W-1:0] tag;
    logic [1:0]                rdy;
    logic [IQ_PREG_W-1:0]      dst;
    logic [IQ_CTRL_W-1:0]      ctrl;
  } iq_entry_t;

  // Dispatch package as produced by the dispatch stage for one queue.
  typedef struct packed {
    logic                      valid;
    logic [1:0]                choose;
    logic [3:0][IQ_DATA_W-1:0] data;
    logic [3:0][IQ_PREG_W-1:0] preg;
    logic [3:0]                data_valid;
    logic [1:0][IQ_PREG_W-1:0] dst;
    logic [1:0][IQ_CTRL_W-1:0] ctrl;
  } p_i_pkg_t;

  typedef struct packed {
    logic                 valid;
    logic [IQ_PREG_W-1:0] preg;
    logic [IQ_DATA_W-1:0] data;
  } cdb_wakeup_t;

endpackage

// File: rtl/p_issue_queue_if.sv
// Dispatch, CDB wakeup and FU issue signals of one issue queue.
interface p_issue_queue_if import p_issue_queue_pkg::*; #(
  parameter int DEPTH  = IQ_DEPTH,
  parameter int DATA_W = IQ_DATA_W,
  parameter int PREG_W = IQ_PREG_W,
  parameter int CTRL_W = IQ_CTRL_W
);
  logic                         flush_i;
  logic                         disp_valid_i;
  logic                         disp_ready_o;
  logic [1:0]                   disp_choose_i;
  logic [4*DATA_W-1:0]          disp_data_i;
  logic [4*PREG_W-1:0]          disp_preg_i;
  logic [3:0]                   disp_data_valid_i;
  logic [2*PREG_W-1:0]          disp_dst_i;
  logic [2*CTRL_W-1:0]          disp_ctrl_i;
  logic [1:0]                   cdb_valid_i;
  logic [2*PREG_W-1:0]          cdb_preg_i;
  logic [2*DATA_W-1:0]          cdb_data_i;
  logic                         issue_valid_o;
  logic                         issue_ready_i;
  logic [2*DATA_W-1:0]          issue_data_o;
  logic [PREG_W-1:0]            issue_dst_o;
  logic [CTRL_W-1:0]            issue_ctrl_o;
  logic [$clog2(DEPTH+1)-1:0]   count_o;

  modport master (
    output flush_i, disp_valid_i, disp_choose_i, disp_data_i, disp_preg_i,
           disp_data_valid_i, disp_dst_i, disp_ctrl_i, cdb_valid_i, cdb_preg_i,
           cdb_data_i, issue_ready_i,
    input  disp_ready_o, issue_valid_o, issue_data_o, issue_dst_o, issue_ctrl_o,
           count_o
  );

  modport slave (
    input  flush_i, disp_valid_i, disp_choose_i, disp_data_i, disp_preg_i,
           disp_data_valid_i, disp_dst_i, disp_ctrl_i, cdb_valid_i, cdb_preg_i,
           cdb_data_i, issue_ready_i,
    output disp_ready_o, issue_valid_o, issue_data_o, issue_dst_o, issue_ctrl_o,
           count_o
  );
endinterface

// File: rtl/p_issue_queue_select.sv
// Find-first-set over the entry ready vector; bit 0 is the oldest slot.
module p_iq_select import p_issue_queue_pkg::*; #(
  parameter int N = IQ_DEPTH
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic         vld
);
  always_comb begin
    gnt = '0;
    vld = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req[i] && !vld) begin
        gnt[i] = 1'b1;
        vld    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/p_issue_queue.sv
// Collapsing, age-ordered issue queue: two-wide append, CDB operand capture,
// oldest-ready single issue.
module p_issue_queue import p_issue_queue_pkg::*; #(
  parameter int DEPTH  = IQ_DEPTH,
  parameter int DATA_W = IQ_DATA_W,
  parameter int PREG_W = IQ_PREG_W,
  parameter int CTRL_W = IQ_CTRL_W
) (
  input  logic            clk,
  input  logic            rst_n,
  p_issue_queue_if.slave  bus
);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH-2);

  typedef struct packed {
    logic [1:0][DATA_W-1:0] data;
    logic [1:0][PREG_W-1:0] tag;
    logic [1:0]             rdy;
    logic [PREG_W-1:0]      dst;
    logic [CTRL_W-1:0]      ctrl;
  } entry_t;

  entry_t                  q     [DEPTH];
  entry_t                  q_nxt [DEPTH];
  entry_t                  woke  [DEPTH+1];
  entry_t                  new_e [2];
  entry_t                  sel_e;
  logic [CNT_W-1:0]        count, count_nxt, base;
  logic [DEPTH-1:0]        rdy_vec, gnt, shift;
  logic                    sel_vld, issue_fire, disp_fire, ins0, ins1;
  logic [1:0]              cdb_v;
  logic [1:0][PREG_W-1:0]  cdb_p;
  logic [1:0][DATA_W-1:0]  cdb_d;

  assign cdb_v = bus.cdb_valid_i;
  assign cdb_p = bus.cdb_preg_i;
  assign cdb_d = bus.cdb_data_i;

  // Later ports override earlier ones, so port 1 wins a double match.
  function automatic entry_t wake(entry_t e, logic [1:0] v,
                                  logic [1:0][PREG_W-1:0] p,
                                  logic [1:0][DATA_W-1:0] d);
    entry_t r;
    r = e;
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 2; j++) begin
        if (!e.rdy[k] && v[j] && (p[j] == e.tag[k])) begin
          r.rdy[k]  = 1'b1;
          r.data[k] = d[j];
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      rdy_vec[i] = (CNT_W'(i) < count) && (&q[i].rdy);
    end
  end

  p_iq_select #(.N(DEPTH)) u_select (
    .req (rdy_vec),
    .gnt (gnt),
    .vld (sel_vld)
  );

  always_comb begin
    sel_e = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (gnt[i]) sel_e = q[i];
    end
  end

  assign bus.issue_valid_o = sel_vld && !bus.flush_i;
  assign bus.issue_data_o  = sel_e.data;
  assign bus.issue_dst_o   = sel_e.dst;
  assign bus.issue_ctrl_o  = sel_e.ctrl;
  assign bus.count_o       = count;
  // Ready looks only at registered occupancy; a same-cycle issue never opens room.
  assign bus.disp_ready_o  = (count <= READY_MAX) && !bus.flush_i;

  assign issue_fire = bus.issue_valid_o && bus.issue_ready_i;
  assign disp_fire  = bus.disp_valid_i && bus.disp_ready_o;
  assign ins0       = disp_fire && bus.disp_choose_i[0];
  assign ins1       = disp_fire && bus.disp_choose_i[1];
  assign base       = count - CNT_W'(issue_fire);

  always_comb begin
    entry_t raw;
    for (int i = 0; i < 2; i++) begin
      raw = '0;
      for (int k = 0; k < 2; k++) begin
        raw.data[k] = bus.disp_data_i[(2*i+k)*DATA_W +: DATA_W];
        raw.tag[k]  = bus.disp_preg_i[(2*i+k)*PREG_W +: PREG_W];
        raw.rdy[k]  = bus.disp_data_valid_i[2*i+k];
      end
      raw.dst  = bus.disp_dst_i[i*PREG_W +: PREG_W];
      raw.ctrl = bus.disp_ctrl_i[i*CTRL_W +: CTRL_W];
      new_e[i] = wake(raw, cdb_v, cdb_p, cdb_d);
    end
  end

  // Slots at or above the issued one take their younger neighbour.
  always_comb begin
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      acc      = acc | gnt[i];
      shift[i] = issue_fire && acc;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woke[i] = wake(q[i], cdb_v, cdb_p, cdb_d);
    end
    woke[DEPTH] = woke[DEPTH-1];
    for (int i = 0; i < DEPTH; i++) begin
      q_nxt[i] = shift[i] ? woke[i+1] : woke[i];
      if (ins0 && (CNT_W'(i) == base)) q_nxt[i] = new_e[0];
      if (ins1 && (CNT_W'(i) == base + CNT_W'(ins0))) q_nxt[i] = new_e[1];
    end
  end

  assign count_nxt = bus.flush_i ? '0 : base + CNT_W'(ins0) + CNT_W'(ins1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count <= '0;
    else        count <= count_nxt;
  end

  // Entry payload is qualified by count, so it carries no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) q[i] <= q_nxt[i];
  end

endmodule

// File: tb/tb_p_issue_queue.sv
// Bench for p_issue_queue: directed scenarios plus randomized traffic, all checked
// against a queue-level reference model.
module tb_p_issue_queue;
  import p_issue_queue_pkg::*;

  localparam int DEPTH  = IQ_DEPTH;
  localparam int DATA_W = IQ_DATA_W;
  localparam int PREG_W = IQ_PREG_W;
  localparam int CTRL_W = IQ_CTRL_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   chk_en = 1'b0;

  p_issue_queue_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .PREG_W(PREG_W), .CTRL_W(CTRL_W)) bus();

  p_issue_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .PREG_W(PREG_W), .CTRL_W(CTRL_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0][DATA_W-1:0] d;
    logic [1:0][PREG_W-1:0] t;
    logic [1:0]             r;
    logic [PREG_W-1:0]      dst;
    logic [CTRL_W-1:0]      ctrl;
  } m_ent_t;

  m_ent_t mq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic m_ent_t m_wake(m_ent_t e);
    m_ent_t r;
    r = e;
    for (int k = 0; k < 2; k++) begin
      if (!e.r[k]) begin
        for (int j = 0; j < 2; j++) begin
          if (bus.cdb_valid_i[j] && bus.cdb_preg_i[j*PREG_W +: PREG_W] == e.t[k]) begin
            r.r[k] = 1'b1;
            r.d[k] = bus.cdb_data_i[j*DATA_W +: DATA_W];
          end
        end
      end
    end
    return r;
  endfunction

  function automatic int m_sel();
    for (int i = 0; i < mq.size(); i++) begin
      if (mq[i].r == 2'b11) return i;
    end
    return -1;
  endfunction

  function automatic m_ent_t m_new(int i);
    m_ent_t e;
    for (int k = 0; k < 2; k++) begin
      e.d[k] = bus.disp_data_i[(2*i+k)*DATA_W +: DATA_W];
      e.t[k] = bus.disp_preg_i[(2*i+k)*PREG_W +: PREG_W];
      e.r[k] = bus.disp_data_valid_i[2*i+k];
    end
    e.dst  = bus.disp_dst_i[i*PREG_W +: PREG_W];
    e.ctrl = bus.disp_ctrl_i[i*CTRL_W +: CTRL_W];
    return m_wake(e);
  endfunction

  task automatic model_step();
    int sel;
    bit fire;
    if (bus.flush_i) begin
      mq.delete();
      return;
    end
    sel  = m_sel();
    fire = bus.disp_valid_i && (mq.size() <= DEPTH-2);
    for (int i = 0; i < mq.size(); i++) mq[i] = m_wake(mq[i]);
    if (sel >= 0 && bus.issue_ready_i) mq.delete(sel);
    for (int i = 0; i < 2; i++) begin
      if (fire && bus.disp_choose_i[i]) mq.push_back(m_new(i));
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) mq.delete();
      else        model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        int s;
        bit ev;
        s  = m_sel();
        ev = (s >= 0) && !bus.flush_i;
        chk("count", 64'(bus.count_o), 64'(mq.size()));
        chk("disp_ready", 64'(bus.disp_ready_o), 64'((mq.size() <= DEPTH-2) && !bus.flush_i));
        chk("issue_valid", 64'(bus.issue_valid_o), 64'(ev));
        if (ev) begin
          chk("issue_data", 64'(bus.issue_data_o), 64'(mq[s].d));
          chk("issue_dst", 64'(bus.issue_dst_o), 64'(mq[s].dst));
          chk("issue_ctrl", 64'(bus.issue_ctrl_o), 64'(mq[s].ctrl));
        end
      end
    end
  end

  task automatic idle();
    bus.flush_i = 1'b0;        bus.disp_valid_i = 1'b0;   bus.disp_choose_i = '0;
    bus.disp_data_i = '0;      bus.disp_preg_i = '0;      bus.disp_data_valid_i = '0;
    bus.disp_dst_i = '0;       bus.disp_ctrl_i = '0;      bus.cdb_valid_i = '0;
    bus.cdb_preg_i = '0;       bus.cdb_data_i = '0;       bus.issue_ready_i = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.disp_valid_i = 1'b0;
    bus.cdb_valid_i  = '0;
    bus.flush_i      = 1'b0;
  endtask

  task automatic set_inst(input int i, input logic [PREG_W-1:0] d, input logic v0,
                          input logic [PREG_W-1:0] tag0, input logic [DATA_W-1:0] d0);
    bus.disp_data_i[(2*i)*DATA_W +: DATA_W]   = d0;
    bus.disp_data_i[(2*i+1)*DATA_W +: DATA_W] = DATA_W'(32'h1000 + 32'(d));
    bus.disp_preg_i[(2*i)*PREG_W +: PREG_W]   = tag0;
    bus.disp_preg_i[(2*i+1)*PREG_W +: PREG_W] = '0;
    bus.disp_data_valid_i[2*i]   = v0;
    bus.disp_data_valid_i[2*i+1] = 1'b1;
    bus.disp_dst_i[i*PREG_W +: PREG_W]  = d;
    bus.disp_ctrl_i[i*CTRL_W +: CTRL_W] = CTRL_W'(16'hC000 + 16'(d));
  endtask

  task automatic disp(input logic [1:0] ch);
    bus.disp_valid_i  = 1'b1;
    bus.disp_choose_i = ch;
  endtask

  task automatic cdb(input int port, input logic [PREG_W-1:0] tag, input logic [DATA_W-1:0] d);
    bus.cdb_valid_i[port] = 1'b1;
    bus.cdb_preg_i[port*PREG_W +: PREG_W] = tag;
    bus.cdb_data_i[port*DATA_W +: DATA_W] = d;
  endtask

  initial begin
    logic [2*DATA_W-1:0] idata;
    idle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    chk("rst_count", 64'(bus.count_o), 64'(0));
    chk("rst_valid", 64'(bus.issue_valid_o), 64'(0));
    chk("rst_ready", 64'(bus.disp_ready_o), 64'(1));

    // Two ready instructions issue back to back.
    set_inst(0, 5, 1'b1, 0, 32'hA5); set_inst(1, 6, 1'b1, 0, 32'hA6);
    disp(2'b11); bus.issue_ready_i = 1'b1;
    tick();
    chk("t1_count", 64'(bus.count_o), 64'(2));
    chk("t1_dst5", 64'(bus.issue_dst_o), 64'(5));
    tick();
    chk("t1_dst6", 64'(bus.issue_dst_o), 64'(6));
    chk("t1_count1", 64'(bus.count_o), 64'(1));
    tick();
    chk("t1_empty", 64'(bus.issue_valid_o), 64'(0));

    // Wait on tag 9; woken by CDB port 1 three cycles later.
    bus.issue_ready_i = 1'b0;
    set_inst(0, 7, 1'b0, 9, 32'h0); disp(2'b01);
    tick();
    chk("t2_wait1", 64'(bus.issue_valid_o), 64'(0));
    tick();
    chk("t2_wait2", 64'(bus.issue_valid_o), 64'(0));
    tick();
    cdb(1, 9, 32'hDEADBEEF);
    #1 chk("t2_no_same_cycle", 64'(bus.issue_valid_o), 64'(0));
    tick();
    idata = bus.issue_data_o;
    chk("t2_valid", 64'(bus.issue_valid_o), 64'(1));
    chk("t2_src0", 64'(idata[DATA_W-1:0]), 64'(32'hDEADBEEF));
    bus.issue_ready_i = 1'b1;
    tick();
    chk("t2_drained", 64'(bus.count_o), 64'(0));
    bus.issue_ready_i = 1'b0;

    // Fill, full threshold, issue plus dispatch at six, flush.
    set_inst(0, 1, 1'b1, 0, 32'h11); set_inst(1, 2, 1'b0, 40, 0); disp(2'b11); tick();
    set_inst(0, 3, 1'b0, 40, 0); set_inst(1, 4, 1'b0, 40, 0); disp(2'b11); tick();
    set_inst(0, 5, 1'b0, 40, 0); set_inst(1, 6, 1'b0, 40, 0); disp(2'b11); tick();
    chk("t3_count6", 64'(bus.count_o), 64'(6));
    chk("t3_ready6", 64'(bus.disp_ready_o), 64'(1));
    chk("t3_head", 64'(bus.issue_dst_o), 64'(1));
    set_inst(0, 7, 1'b0, 40, 0); disp(2'b01); bus.issue_ready_i = 1'b1;
    tick();
    chk("t3_swap_count", 64'(bus.count_o), 64'(6));
    bus.issue_ready_i = 1'b0;
    set_inst(0, 8, 1'b0, 40, 0); disp(2'b01);
    tick();
    chk("t3_count7", 64'(bus.count_o), 64'(7));
    chk("t3_ready7", 64'(bus.disp_ready_o), 64'(0));
    disp(2'b11);
    tick();
    chk("t3_blocked", 64'(bus.count_o), 64'(7));
    bus.flush_i = 1'b1;
    #1 chk("t3_flush_ready", 64'(bus.disp_ready_o), 64'(0));
    tick();
    chk("t3_flushed", 64'(bus.count_o), 64'(0));

    // Oldest-first selection.
    set_inst(0, 10, 1'b0, 20, 0); set_inst(1, 11, 1'b0, 21, 0); disp(2'b11); tick();
    set_inst(0, 12, 1'b0, 22, 0); disp(2'b01); tick();
    cdb(0, 22, 32'h2222);
    tick();
    chk("t4_young_first", 64'(bus.issue_dst_o), 64'(12));
    bus.issue_ready_i = 1'b1;
    tick();
    chk("t4_count2", 64'(bus.count_o), 64'(2));
    bus.issue_ready_i = 1'b0;
    cdb(0, 20, 32'h2020); cdb(1, 21, 32'h2121);
    tick();
    idata = bus.issue_data_o;
    chk("t4_oldest", 64'(bus.issue_dst_o), 64'(10));
    chk("t4_src0", 64'(idata[DATA_W-1:0]), 64'(32'h2020));
    bus.issue_ready_i = 1'b1;
    tick();
    chk("t4_next", 64'(bus.issue_dst_o), 64'(11));
    tick();
    chk("t4_empty", 64'(bus.count_o), 64'(0));
    bus.issue_ready_i = 1'b0;

    // Broadcast in the dispatch fire cycle is captured.
    set_inst(0, 13, 1'b0, 12, 0); disp(2'b01); cdb(0, 12, 32'h12345678);
    tick();
    idata = bus.issue_data_o;
    chk("t5_valid", 64'(bus.issue_valid_o), 64'(1));
    chk("t5_src0", 64'(idata[DATA_W-1:0]), 64'(32'h12345678));
    bus.issue_ready_i = 1'b1;
    tick();
    bus.issue_ready_i = 1'b0;

    // Flush with five ready entries and the FU accepting.
    set_inst(0, 1, 1'b1, 0, 1); set_inst(1, 2, 1'b1, 0, 2);
    disp(2'b11); tick(); disp(2'b11); tick(); disp(2'b01); tick();
    chk("t6_count5", 64'(bus.count_o), 64'(5));
    bus.issue_ready_i = 1'b1; bus.flush_i = 1'b1;
    #1 chk("t6_no_issue", 64'(bus.issue_valid_o), 64'(0));
    tick();
    chk("t6_count0", 64'(bus.count_o), 64'(0));
    bus.issue_ready_i = 1'b0;

    // Asynchronous reset in the middle of a dispatch.
    disp(2'b11);
    tick();
    chk("t7_count2", 64'(bus.count_o), 64'(2));
    disp(2'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_rst_valid", 64'(bus.issue_valid_o), 64'(0));
    chk("t7_rst_count", 64'(bus.count_o), 64'(0));
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int c = 0; c < 3000; c++) begin
      bus.flush_i       = ($urandom_range(0, 39) == 0);
      bus.disp_valid_i  = 1'($urandom_range(0, 1));
      bus.disp_choose_i = 2'($urandom_range(0, 3));
      for (int n = 0; n < 4; n++) begin
        bus.disp_data_i[n*DATA_W +: DATA_W] = DATA_W'($urandom);
        bus.disp_preg_i[n*PREG_W +: PREG_W] = PREG_W'($urandom_range(0, 7));
        bus.disp_data_valid_i[n]            = 1'($urandom_range(0, 1));
      end
      for (int n = 0; n < 2; n++) begin
        bus.disp_dst_i[n*PREG_W +: PREG_W]  = PREG_W'($urandom);
        bus.disp_ctrl_i[n*CTRL_W +: CTRL_W] = CTRL_W'($urandom);
        bus.cdb_preg_i[n*PREG_W +: PREG_W]  = PREG_W'($urandom_range(0, 7));
        bus.cdb_data_i[n*DATA_W +: DATA_W]  = DATA_W'($urandom);
      end
      bus.cdb_valid_i   = 2'($urandom_range(0, 3));
      bus.issue_ready_i = ($urandom_range(0, 9) < 7);
      tick();
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
